// File: rtl/skew_shift_register.sv
// -----------------------------------------------------------------------------
// skew_shift_register
//
// Column-skewed stimulus register for the compressor partial-product tree of an
// N x N multiplier. There are COLS = 2N-1 independent shift chains. Column i
// has depth d(i) = min(i+1, 2N-1-i), so it always presents the last d(i) bits
// that arrived on src[i]. Bit 0 of every column is the newest bit.
//
// Fill tracking tells a pipelined wrapper when every column holds data accepted
// since the last reset/clear. A free-running shift counter counts accepted
// shifts since reset and is deliberately left alone by clear.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (highest priority)
//   i_en         shift enable; every column shifts in one bit
//   i_clr        synchronous clear of data and fill state (shift count kept)
//   i_src        one new bit per column, i_src[i] enters column i
//   o_col_bits   all column chains packed column-major, column 0 at the LSBs
//   o_col_valid  bit i set once column i is completely filled
//   o_full       every column is valid
//   o_fill_cnt   shifts since last reset/clear, saturating at N
//   o_shift_cnt  accepted shifts since reset, wrapping
// -----------------------------------------------------------------------------
module skew_shift_register #(
    parameter int N     = 14,
    parameter int CNT_W = 16,
    localparam int COLS   = 2 * N - 1,
    localparam int TOT    = N * N,
    localparam int FILL_W = $clog2(N + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [COLS-1:0]   i_src,
    output logic [TOT-1:0]    o_col_bits,
    output logic [COLS-1:0]   o_col_valid,
    output logic              o_full,
    output logic [FILL_W-1:0] o_fill_cnt,
    output logic [CNT_W-1:0]  o_shift_cnt
);

    // Triangular depth profile: columns grow by one bit up to the centre
    // column N-1 (depth N) and then shrink back down to depth 1.
    function automatic int colDepth(input int idx);
        return (idx < N) ? (idx + 1) : (2 * N - 1 - idx);
    endfunction

    // Bit offset of a column inside the packed output: the sum of the depths
    // of all lower-numbered columns.
    function automatic int colOffset(input int idx);
        int acc;
        acc = 0;
        for (int j = 0; j < idx; j++) begin
            acc += colDepth(j);
        end
        return acc;
    endfunction

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);

    logic [FILL_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0]  r_shift_cnt;
    logic              w_shift;

    // A shift only happens when neither reset nor clear overrides it.
    assign w_shift = i_en && !i_clr && !i_rst;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D   = colDepth(c);
        localparam int OFF = colOffset(c);
        localparam logic [FILL_W-1:0] D_F = FILL_W'(D);

        logic [D-1:0] r_chain;

        // Each column is a plain shift register. Concatenating the new bit
        // below the whole chain and truncating back to D bits drops the
        // oldest bit, and also covers depth-1 columns without a special case.
        always_ff @(posedge i_clk) begin
            if (i_rst || i_clr) begin
                r_chain <= '0;
            end else if (w_shift) begin
                r_chain <= D'({r_chain, i_src[c]});
            end
        end

        assign o_col_bits[OFF +: D] = r_chain;

        // A column is complete once at least D shifts landed since the last
        // reset/clear; the fill counter saturating at N keeps this true.
        assign o_col_valid[c] = (r_fill_cnt >= D_F);
    end

    // Fill counter: counts accepted shifts since reset/clear and stops at N,
    // which is the depth of the deepest (centre) column.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_fill_cnt <= '0;
        end else if (w_shift && (r_fill_cnt != FILL_MAX)) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    // Shift counter: free-running modulo 2^CNT_W, cleared only by reset so a
    // clear mid-stream does not lose the running shift total.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift_cnt <= '0;
        end else if (w_shift) begin
            r_shift_cnt <= r_shift_cnt + 1'b1;
        end
    end

    assign o_full      = (r_fill_cnt == FILL_MAX);
    assign o_fill_cnt  = r_fill_cnt;
    assign o_shift_cnt = r_shift_cnt;

endmodule

// File: doc/skew_shift_register.md
Name: skew_shift_register

Overview:
- Parametrised successor of the fixed 14-bit column-skew stimulus register that feeds the `compressor` partial-product tree.
- Holds 2N-1 per-column shift chains with triangular depths d(i) = min(i+1, 2N-1-i), so column i presents its last d(i) input bits to the compressor.
- Adds synchronous reset, shift enable, clear, per-column fill tracking and a shift counter, so benches and pipelined multiplier wrappers can tell when every column holds valid data.

Parameters:
- N, 14, multiplier operand width; number of columns COLS = 2N-1; total stored bits TOT = N*N.
- CNT_W, 16, width of the free-running shift counter; wraps modulo 2^CNT_W.
- FILL_W, $clog2(N+1), width of the fill counter (derived; not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  shift enable: when 1, every column shifts in one bit this cycle.
- clr  in  1  synchronous clear of data and fill state; shift_cnt is kept.
- src  in  COLS  new bit per column; src[i] enters column i.
- col_bits  out  TOT  all column chains packed column-major.
- col_valid  out  COLS  bit i = 1 when column i is completely filled since the last rst/clr.
- full  out  1  all columns valid (fill_cnt == N).
- fill_cnt  out  FILL_W  number of shifts since last rst/clr, saturating at N.
- shift_cnt  out  CNT_W  total accepted shifts since rst, wrapping.

Behaviour:
- Depths: d(i) = i+1 for i < N; d(i) = 2N-1-i for i >= N. Offset off(i) = sum over j<i of d(j). Column i occupies col_bits[off(i)+d(i)-1 : off(i)].
- Shift rule: on a clk edge with en=1, column i becomes {column i[d(i)-2:0], src[i]}. Bit 0 is the newest bit; bit k is the bit accepted k shifts earlier. The oldest bit is dropped. A depth-1 column is simply replaced by src[i].
- Latency: src sampled at edge E appears at col_bits[off(i)] immediately after E. All outputs are register-driven, with no combinational path from inputs to outputs.
- en=0: all state holds, including both counters.
- fill_cnt: increments on each accepted shift and saturates at N. col_valid[i] = (fill_cnt >= d(i)). full = (fill_cnt == N). Column N-1 (depth N) is the last to become valid.
- shift_cnt: increments on each accepted shift and wraps from 2^CNT_W-1 to 0. It is not affected by clr.
- Priority: rst > clr > en.
  - rst=1: all column bits, fill_cnt and shift_cnt go to 0. The en/src of that cycle are ignored.
  - clr=1 (rst=0): all column bits and fill_cnt go to 0; shift_cnt holds. en/src are ignored, so no shift happens and shift_cnt does not increment.
- Reset values: col_bits=0, col_valid=0, full=0, fill_cnt=0, shift_cnt=0.
- Reset or clr mid-fill discards partial data; refill starts from fill_cnt=0 on the next accepted shift.
- N=1 is legal: one column of depth 1, and full is asserted after the first shift.

Test Plan (N=4: COLS=7, depths 1,2,3,4,3,2,1, offsets 0,1,3,6,10,13,15, TOT=16):
- rst for 1 cycle -> col_bits=16'h0000, col_valid=7'b0000000, full=0, fill_cnt=0, shift_cnt=0.
- en=1 with src=7'h7F for 1 cycle, then src=7'h00 for 3 cycles:
  - after shift 1: col_bits bits 0,1,3,6,10,13,15 set, col_valid=7'b1000001.
  - after shift 4: col_bits = only bit 9 set (column 3, bit 3); col_valid=7'h7F, full=1, fill_cnt=4.
- en toggling 1,0,1,0 with src=7'h7F -> state changes only on en=1 cycles; after 4 cycles fill_cnt=2, shift_cnt=2.
- Fill to full, then assert clr and en=1 together -> col_bits=0, fill_cnt=0, full=0, shift_cnt unchanged (4). Next en=1 with src=7'h01 -> col_bits=16'h0001.
- CNT_W=3: 9 accepted shifts after rst -> shift_cnt=1, fill_cnt=4. rst asserted with en=1 -> shift_cnt=0.
- Random src stream, 1000 cycles with random en/clr -> every column equals the last d(i) accepted src[i] bits (newest at bit 0), checked against a scoreboard model.
